// File: rtl/kbeckmann_01.sv
// Four-channel 8-bit PWM generator with a byte-wide register write port.
// Duty values are double-buffered and copied into the active set only at the phase wrap while running.
module kbeckmann_01 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] duty [4];
    logic [7:0] act  [4];
    logic [7:0] prescale;
    logic [7:0] ctrl;
    logic [7:0] pc;
    logic [7:0] ph;
    logic [3:0] pwm;

    logic [2:0] addr;
    logic       strobe;
    logic       run;
    logic       tick;

    assign addr   = uio_in[2:0];
    assign strobe = uio_in[3];
    assign run    = ctrl[4];
    // ">=" so that lowering the prescaler below the current count ticks on the next edge.
    assign tick   = (pc >= prescale);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                duty[i] <= 8'd0;
                act[i]  <= 8'd0;
            end
            prescale <= 8'd0;
            ctrl     <= 8'd0;
            pc       <= 8'd0;
            ph       <= 8'd0;
        end else if (ena) begin
            if (strobe) begin
                case (addr)
                    3'd0, 3'd1, 3'd2, 3'd3: duty[addr[1:0]] <= ui_in;
                    3'd4:                   prescale <= ui_in;
                    3'd5:                   ctrl <= ui_in;
                    default:                ;
                endcase
            end
            // Counting uses the pre-write RUN/P values of this same edge.
            if (run) begin
                if (tick) begin
                    pc <= 8'd0;
                    ph <= ph + 8'd1;
                    if (ph == 8'hFF) begin
                        for (int i = 0; i < 4; i++) act[i] <= duty[i];
                    end
                end else begin
                    pc <= pc + 8'd1;
                end
            end else begin
                for (int i = 0; i < 4; i++) act[i] <= duty[i];
            end
        end
    end

    always_comb begin
        pwm = 4'b0000;
        for (int i = 0; i < 4; i++) pwm[i] = ctrl[i] & (ph < act[i]);
    end

    assign uo_out  = {ph[7:4], pwm};
    assign uio_out = {ph[3:0], 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_kbeckmann_01.sv
// Directed bench for kbeckmann_01: reset, PWM duty, prescaler, double buffering, edge duties, enable gating.
module tb_kbeckmann_01;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] phase;

    int n_checks = 0;
    int n_pass   = 0;

    kbeckmann_01 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    assign phase = {uo_out[7:4], uio_out[7:4]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        ui_in  = data;
        uio_in = {4'b0000, 1'b1, addr};
        step(1);
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(2);
        rst_n = 1'b0;
    endtask

    initial begin
        int hi, lo, lo_ph, bad_ph, bad_pwm, ph0;
        logic [7:0] ph_m;
        logic [7:0] d_m;
        logic       exp_pwm;

        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset state
        do_reset();
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hF0);

        // Basic PWM: D0=64, P=0, E0+RUN
        wr(3'd0, 8'd64);
        wr(3'd4, 8'd0);
        wr(3'd5, 8'h11);
        check("basic_phase_start", phase, 8'd0);
        hi = 0; bad_ph = 0; bad_pwm = 0;
        for (int i = 0; i < 256; i++) begin
            if (phase != 8'(i)) bad_ph++;
            if (uo_out[0] !== (i < 64)) bad_pwm++;
            if (uo_out[0]) hi++;
            step(1);
        end
        check("basic_pwm0_high", hi, 64);
        check("basic_pwm0_shape", bad_pwm, 0);
        check("basic_phase_seq", bad_ph, 0);
        check("basic_phase_wrap", phase, 8'd0);

        // Prescaler P=3
        do_reset();
        wr(3'd0, 8'd64);
        wr(3'd4, 8'd3);
        wr(3'd5, 8'h11);
        step(3);
        check("presc_hold_3", phase, 8'd0);
        step(1);
        check("presc_tick_4", phase, 8'd1);
        hi = 0;
        for (int i = 0; i < 1024; i++) begin
            if (uo_out[0]) hi++;
            step(1);
        end
        check("presc_period_high", hi, 256);
        check("presc_period_phase", phase, 8'd1);
        // PC now 0; advance to PC=2, then the P=1 write edge takes PC to 3
        step(2);
        wr(3'd4, 8'd1);
        check("presc_lower_before", phase, 8'd1);
        step(1);
        check("presc_lower_tick", phase, 8'd2);
        step(2);
        check("presc_p1_period", phase, 8'd3);

        // Double buffering on channel 1
        do_reset();
        wr(3'd1, 8'd200);
        wr(3'd4, 8'd0);
        wr(3'd5, 8'h12);
        step(50);
        check("dbuf_phase50", phase, 8'd50);
        wr(3'd1, 8'd10);
        bad_ph = 0; bad_pwm = 0;
        for (int k = 0; k < 461; k++) begin
            ph_m    = 8'(51 + k);
            d_m     = (k < 205) ? 8'd200 : 8'd10;
            exp_pwm = (ph_m < d_m);
            if (phase != ph_m) bad_ph++;
            if (uo_out[1] !== exp_pwm) bad_pwm++;
            if (k == 49) check("dbuf_old_duty_ph100", uo_out[1], 1'b1);
            if (k == 305) check("dbuf_new_duty_ph100", uo_out[1], 1'b0);
            step(1);
        end
        check("dbuf_pwm1_shape", bad_pwm, 0);
        check("dbuf_phase_seq", bad_ph, 0);

        // Edge duties: D2=0, D3=255
        do_reset();
        wr(3'd2, 8'd0);
        wr(3'd3, 8'd255);
        wr(3'd5, 8'h1C);
        hi = 0; lo = 0; lo_ph = -1;
        for (int i = 0; i < 256; i++) begin
            if (uo_out[2]) hi++;
            if (!uo_out[3]) begin
                lo++;
                lo_ph = int'(phase);
            end
            step(1);
        end
        check("edge_pwm2_never", hi, 0);
        check("edge_pwm3_low_count", lo, 1);
        check("edge_pwm3_low_phase", lo_ph, 255);
        check("edge_pwm3_high_ph0", uo_out[3], 1'b1);
        wr(3'd5, 8'h14);
        check("edge_e3_clear", uo_out[3], 1'b0);

        // ena=0 with strobe held: nothing changes
        ph0    = int'(phase);
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h0D;
        step(5);
        check("ena_phase_frozen", phase, 8'(ph0));
        uio_in = 8'h00;
        ena    = 1'b1;
        step(1);
        check("ena_resume_run", phase, 8'(ph0 + 1));

        // Unmapped write leaves counting untouched
        wr(3'd6, 8'h00);
        check("unmapped_ignored", phase, 8'(ph0 + 2));

        // Mid-period reset
        step(37);
        rst_n = 1'b1;
        step(1);
        check("midreset_phase", phase, 8'd0);
        check("midreset_uo_out", uo_out, 8'h00);
        rst_n = 1'b0;
        step(3);
        check("after_reset_idle", phase, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kbeckmann_01.md
# kbeckmann_01

Four-channel 8-bit PWM generator with a byte-wide register write port. It is the top-level user block of the tile. ui_in carries write data, uio_in[3:0] carries the address and write strobe, uo_out[3:0] drives the PWM outputs, and the running phase counter is exported for observation. Duty updates are double-buffered so they never glitch a PWM period.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-high: rst_n=1 at a rising clk edge resets the block; rst_n=0 is normal operation.
- ena  input  1  block enable; 0 freezes all state (no writes, no counting).
- ui_in  input  8  write data.
- uio_in  input  8  [2:0] register address, [3] write strobe, [7:4] ignored.
- uo_out  output  8  [3:0] PWM channels 0..3, [7:4] phase[7:4].
- uio_out  output  8  [7:4] phase[3:0], [3:0] constant 0.
- uio_oe  output  8  constant 8'hF0.

## Operation
- Registers (all 8-bit, reset to 0):
  - addr 0..3: shadow duty D0..D3.
  - addr 4: prescaler P.
  - addr 5: control; [3:0] channel enables E0..E3, [4] RUN, [7:5] stored but unused.
  - addr 6, 7: unmapped; writes are ignored.
- Write: if ena=1 and uio_in[3]=1 at an edge, reg[uio_in[2:0]] <= ui_in. The strobe is level-sensitive, so one write occurs per cycle while it is held.
- Internal state, reset to 0: 8-bit prescale counter PC, 8-bit phase counter PH, active duties A0..A3.
- Counting, when ena=1 and RUN=1:
  - If PC >= P: PC <= 0 and a tick occurs.
  - Otherwise PC <= PC+1.
  - On a tick, PH <= PH+1, wrapping 255->0.
  - The ">=" compare makes lowering P below the current PC produce a tick on the next edge.
- When RUN=0: PC and PH hold, and Ai <= Di every cycle, so the new duty applies immediately.
- When RUN=1: Ai <= Di only on a tick where PH=255 (the wrap to 0). This gives glitch-free period updates.
- PWM output: pwm_i = Ei & (PH < Ai). This path is combinational from registers.
  - Ai=0 gives a constant low output.
  - Ai=255 gives high for 255 of 256 phases.
  - The PWM period is 256*(P+1) clocks.
- ena=0: all registers, counters and Ai hold. Outputs keep being driven from the held state.
- Reset: all registers, PC, PH and Ai go to 0, so uo_out=0 and uio_out=0. uio_oe=8'hF0 at all times.

## Timing
- A write at edge N is visible in register state after edge N.
  - A control write affects pwm outputs combinationally from that point.
  - A duty write with RUN=0 propagates to Ai at edge N+1, and pwm updates after N+1.
- A write to control in the same cycle as counting: that edge uses the old RUN, P and E values.
- With P=0, PH increments on every edge while running.
- With P=k, ticks occur every k+1 edges after the first tick.
- Reset has priority over writes and counting in the same cycle.
- A reset mid-period returns PH=0 and Ai=0 immediately after the edge.
- On resume after reset, the block needs register rewrites; no state survives reset.

## Test plan
- Reset: hold rst_n=1 for 2 cycles, then rst_n=0 -> uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
- Basic PWM:
  - Stimulus: write D0=64, then control=0x11 (E0=1, RUN=1), P=0.
  - Required: uo_out[0] high for exactly 64 of every 256 clocks.
  - Required: {uo_out[7:4],uio_out[7:4]} counts 0..255 and wraps.
- Prescaler:
  - Stimulus: P=3, RUN=1.
  - Required: the phase increments every 4 clocks and a full PWM period is 1024 clocks.
  - Stimulus: write P=1 while PC=3.
  - Required: a tick on the next edge.
- Double buffering:
  - Stimulus: running with D1=200 active; write D1=10 at PH=50.
  - Required: pwm1 stays on the 200 duty until PH wraps to 0, then high only for PH<10.
- Edge duties: D2=0 -> pwm2 never high; D3=255 -> pwm3 low only at PH=255. Clearing E3 -> pwm3 low immediately.
- ena/strobe: ena=0 with strobe asserted and RUN=1 -> no register change and PH frozen. Reasserting ena resumes from the held PH.
